sr_task_dispatcher: RTL and testbench

//  Consumer stage directly downstream of the shift-register task queue. Dequeues the head

---
 rtl/sr_task_dispatcher_pkg.sv | 21 ++
 rtl/sr_task_dispatcher_slice_timer.sv | 47 ++++
 rtl/sr_task_dispatcher.sv | 238 +++++++++++++++++++++++
 tb/tb_sr_task_dispatcher.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_task_dispatcher_pkg.sv
// ---------------------------------------------------------------------------
// sr_task_dispatcher_pkg
// Shared scheduler definitions: default widths, the default slice length and
// the dispatcher FSM state encoding. Also imported by the queue cell and the
// scheduler top so every block agrees on the same defaults.
// ---------------------------------------------------------------------------
package sr_task_dispatcher_pkg;

    localparam int TID_W_DEF     = 4;   // task id width
    localparam int INFO_W_DEF    = 32;  // remaining-work word width
    localparam int SLICE_W_DEF   = 8;   // slice counter width
    localparam int SLICE_LEN_DEF = 16;  // cycles per time slice
    localparam int STAT_W        = 16;  // statistics counter width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // waiting for a schedulable head task
        ST_RUN  = 2'd1,  // executing the current task
        ST_SWAP = 2'd2   // offering the current task back to the queue
    } state_t;

endpackage : sr_task_dispatcher_pkg

// File: rtl/sr_task_dispatcher_slice_timer.sv
// ---------------------------------------------------------------------------
// sr_task_dispatcher_slice_timer
// Time-slice down-counter. It reloads on dispatch and counts down while a
// task runs. expire flags the last cycle of the slice (count == 1).
// Ports:
//   clk, rst   clock / asynchronous active-high reset
//   load       reload the counter with load_val (has priority over dec)
//   load_val   slice length to load
//   dec        decrement by one (the counter holds at zero)
//   expire     count == 1
// ---------------------------------------------------------------------------
module sr_task_dispatcher_slice_timer #(
    parameter int SLICE_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [SLICE_W-1:0] load_val,
    input  logic               dec,
    output logic               expire
);

    localparam logic [SLICE_W-1:0] ONE = SLICE_W'(1);

    logic [SLICE_W-1:0] cnt_q;
    logic [SLICE_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == ONE);

endmodule : sr_task_dispatcher_slice_timer

// File: rtl/sr_task_dispatcher.sv
// ---------------------------------------------------------------------------
// sr_task_dispatcher
// Consumer stage behind the shift-register task queue. It dequeues the head
// task {tid, info}, where info is the remaining work, and runs it under a
// time slice. A task leaves by retiring (done or work exhausted), by blocking,
// or by being re-enqueued (preempted or slice expired). All outputs are
// registered.
// Ports:
//   head_valid/head_tid/head_info  queue head task
//   deq                            1-cycle dequeue pulse
//   enq/enq_tid/enq_info           re-enqueue request, held until enq_ready
//   done_req/block_req/preempt_req events for the running task
//   run_valid/run_tid              task currently executing
//   retire_valid/blk_valid/out_tid 1-cycle completion pulses with tid
// Optional feature (macro DISPATCH_STATS_EN):
//   stat_dispatch  saturating count of deq pulses
//   stat_preempt   saturating count of SWAP entries
// ---------------------------------------------------------------------------
module sr_task_dispatcher
    import sr_task_dispatcher_pkg::*;
#(
    parameter int TID_W     = TID_W_DEF,
    parameter int INFO_W    = INFO_W_DEF,
    parameter int SLICE_W   = SLICE_W_DEF,
    parameter int SLICE_LEN = SLICE_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              head_valid,
    input  logic [TID_W-1:0]  head_tid,
    input  logic [INFO_W-1:0] head_info,
    output logic              deq,
    output logic              enq,
    input  logic              enq_ready,
    output logic [TID_W-1:0]  enq_tid,
    output logic [INFO_W-1:0] enq_info,
    input  logic              done_req,
    input  logic              block_req,
    input  logic              preempt_req,
    output logic              run_valid,
    output logic [TID_W-1:0]  run_tid,
    output logic              retire_valid,
    output logic              blk_valid,
    output logic [TID_W-1:0]  out_tid
`ifdef DISPATCH_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_dispatch,
    output logic [STAT_W-1:0] stat_preempt
`endif
);

    localparam logic [INFO_W-1:0] INFO_ONE = INFO_W'(1);

    state_t              state_q, state_d;
    logic [TID_W-1:0]    cur_tid_q, cur_tid_d;
    logic [INFO_W-1:0]   cur_info_q, cur_info_d;
    logic                deq_q, deq_d;
    logic                enq_q, enq_d;
    logic [TID_W-1:0]    enq_tid_q, enq_tid_d;
    logic [INFO_W-1:0]   enq_info_q, enq_info_d;
    logic                run_valid_q, run_valid_d;
    logic [TID_W-1:0]    run_tid_q, run_tid_d;
    logic                retire_valid_q, retire_valid_d;
    logic                blk_valid_q, blk_valid_d;
    logic [TID_W-1:0]    out_tid_q, out_tid_d;
    logic                slice_load, slice_dec, slice_expire;

    sr_task_dispatcher_slice_timer #(
        .SLICE_W (SLICE_W)
    ) u_slice_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (slice_load),
        .load_val (SLICE_W'(SLICE_LEN)),
        .dec      (slice_dec),
        .expire   (slice_expire)
    );

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        state_d        = state_q;
        cur_tid_d      = cur_tid_q;
        cur_info_d     = cur_info_q;
        deq_d          = 1'b0;  // pulses self-clear
        retire_valid_d = 1'b0;
        blk_valid_d    = 1'b0;
        enq_d          = enq_q;
        enq_tid_d      = enq_tid_q;
        enq_info_d     = enq_info_q;
        run_valid_d    = run_valid_q;
        run_tid_d      = run_tid_q;
        out_tid_d      = out_tid_q;
        slice_load     = 1'b0;
        slice_dec      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (head_valid) begin
                    cur_tid_d  = head_tid;
                    cur_info_d = head_info;
                    deq_d      = 1'b1;
                    slice_load = 1'b1;
                    if (head_info == '0) begin
                        // Nothing to run: retire straight from the head.
                        retire_valid_d = 1'b1;
                        out_tid_d      = head_tid;
                    end else begin
                        state_d     = ST_RUN;
                        run_valid_d = 1'b1;
                        run_tid_d   = head_tid;
                    end
                end
            end

            ST_RUN: begin
                // Exit priority: done > block > preempt > work exhausted > slice.
                if (done_req) begin
                    retire_valid_d = 1'b1;
                    out_tid_d      = cur_tid_q;
                    run_valid_d    = 1'b0;
                    state_d        = ST_IDLE;
                end else if (block_req) begin
                    blk_valid_d = 1'b1;
                    out_tid_d   = cur_tid_q;
                    run_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else if (preempt_req) begin
                    // The unit in flight this cycle is not charged.
                    enq_d       = 1'b1;
                    enq_tid_d   = cur_tid_q;
                    enq_info_d  = cur_info_q;
                    run_valid_d = 1'b0;
                    state_d     = ST_SWAP;
                end else if (cur_info_q == INFO_ONE) begin
                    retire_valid_d = 1'b1;
                    out_tid_d      = cur_tid_q;
                    run_valid_d    = 1'b0;
                    state_d        = ST_IDLE;
                end else if (slice_expire) begin
                    // The last slice cycle consumed one unit of work.
                    enq_d       = 1'b1;
                    enq_tid_d   = cur_tid_q;
                    enq_info_d  = cur_info_q - INFO_ONE;
                    run_valid_d = 1'b0;
                    state_d     = ST_SWAP;
                end else begin
                    cur_info_d = cur_info_q - INFO_ONE;
                    slice_dec  = 1'b1;
                end
            end

            ST_SWAP: begin
                if (enq_ready) begin
                    enq_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the async reset clears all of them, dropping any task.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cur_tid_q      <= '0;
            cur_info_q     <= '0;
            deq_q          <= 1'b0;
            enq_q          <= 1'b0;
            enq_tid_q      <= '0;
            enq_info_q     <= '0;
            run_valid_q    <= 1'b0;
            run_tid_q      <= '0;
            retire_valid_q <= 1'b0;
            blk_valid_q    <= 1'b0;
            out_tid_q      <= '0;
        end else begin
            state_q        <= state_d;
            cur_tid_q      <= cur_tid_d;
            cur_info_q     <= cur_info_d;
            deq_q          <= deq_d;
            enq_q          <= enq_d;
            enq_tid_q      <= enq_tid_d;
            enq_info_q     <= enq_info_d;
            run_valid_q    <= run_valid_d;
            run_tid_q      <= run_tid_d;
            retire_valid_q <= retire_valid_d;
            blk_valid_q    <= blk_valid_d;
            out_tid_q      <= out_tid_d;
        end
    end

    assign deq          = deq_q;
    assign enq          = enq_q;
    assign enq_tid      = enq_tid_q;
    assign enq_info     = enq_info_q;
    assign run_valid    = run_valid_q;
    assign run_tid      = run_tid_q;
    assign retire_valid = retire_valid_q;
    assign blk_valid    = blk_valid_q;
    assign out_tid      = out_tid_q;

`ifdef DISPATCH_STATS_EN
    logic [STAT_W-1:0] stat_dispatch_q, stat_dispatch_d;
    logic [STAT_W-1:0] stat_preempt_q, stat_preempt_d;

    // Both counters saturate at all-ones.
    always_comb begin
        stat_dispatch_d = stat_dispatch_q;
        stat_preempt_d  = stat_preempt_q;
        if (deq_d && (stat_dispatch_q != '1)) begin
            stat_dispatch_d = stat_dispatch_q + STAT_W'(1);
        end
        if ((state_q == ST_RUN) && (state_d == ST_SWAP) && (stat_preempt_q != '1)) begin
            stat_preempt_d = stat_preempt_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_dispatch_q <= '0;
            stat_preempt_q  <= '0;
        end else begin
            stat_dispatch_q <= stat_dispatch_d;
            stat_preempt_q  <= stat_preempt_d;
        end
    end

    assign stat_dispatch = stat_dispatch_q;
    assign stat_preempt  = stat_preempt_q;
`endif

endmodule : sr_task_dispatcher

// File: tb/tb_sr_task_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_sr_task_dispatcher
// Self-checking bench for sr_task_dispatcher. Each task's fate is derived
// arithmetically from its work count, the slice length and the event applied
// (exit after min(info, SLICE_LEN) RUN edges, or at the event edge).
// Re-enqueued tasks go into a bench-side queue and are dispatched again later.
// Build with DISPATCH_STATS_EN to also check the statistics counters.
// ---------------------------------------------------------------------------
module tb_sr_task_dispatcher;

    localparam int TID_W     = 4;
    localparam int INFO_W    = 32;
    localparam int SLICE_W   = 8;
    localparam int SLICE_LEN = 4;

    // Event kinds applied during RUN.
    localparam int EV_NONE  = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_BLK   = 2;
    localparam int EV_PRE   = 3;
    localparam int EV_DB    = 4;  // done + block
    localparam int EV_ALL   = 5;  // done + block + preempt
    localparam int EV_BP    = 6;  // block + preempt

    localparam int OUT_RET  = 0;
    localparam int OUT_BLK  = 1;
    localparam int OUT_SWAP = 2;

    logic              clk;
    logic              rst;
    logic              head_valid;
    logic [TID_W-1:0]  head_tid;
    logic [INFO_W-1:0] head_info;
    logic              deq;
    logic              enq;
    logic              enq_ready;
    logic [TID_W-1:0]  enq_tid;
    logic [INFO_W-1:0] enq_info;
    logic              done_req;
    logic              block_req;
    logic              preempt_req;
    logic              run_valid;
    logic [TID_W-1:0]  run_tid;
    logic              retire_valid;
    logic              blk_valid;
    logic [TID_W-1:0]  out_tid;
`ifdef DISPATCH_STATS_EN
    logic [15:0]       stat_dispatch;
    logic [15:0]       stat_preempt;
`endif

    sr_task_dispatcher #(
        .TID_W     (TID_W),
        .INFO_W    (INFO_W),
        .SLICE_W   (SLICE_W),
        .SLICE_LEN (SLICE_LEN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .head_valid   (head_valid),
        .head_tid     (head_tid),
        .head_info    (head_info),
        .deq          (deq),
        .enq          (enq),
        .enq_ready    (enq_ready),
        .enq_tid      (enq_tid),
        .enq_info     (enq_info),
        .done_req     (done_req),
        .block_req    (block_req),
        .preempt_req  (preempt_req),
        .run_valid    (run_valid),
        .run_tid      (run_tid),
        .retire_valid (retire_valid),
        .blk_valid    (blk_valid),
        .out_tid      (out_tid)
`ifdef DISPATCH_STATS_EN
        ,
        .stat_dispatch (stat_dispatch),
        .stat_preempt  (stat_preempt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_disp = 0;  // expected dispatch count since last reset
    int n_swap = 0;  // expected SWAP entries since last reset

    typedef struct {
        logic [TID_W-1:0]  tid;
        logic [INFO_W-1:0] info;
    } task_t;
    task_t pool[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {deq, run_valid, retire_valid, blk_valid, enq}
    function automatic logic [4:0] pulses();
        return {deq, run_valid, retire_valid, blk_valid, enq};
    endfunction

    function automatic logic [63:0] all_outputs();
        return 64'({deq, enq, enq_tid, enq_info, run_valid, run_tid,
                    retire_valid, blk_valid, out_tid});
    endfunction

    task automatic check_stats(input string tag);
`ifdef DISPATCH_STATS_EN
        check({tag, "_stat_dispatch"}, 64'(stat_dispatch), 64'((n_disp > 65535) ? 65535 : n_disp));
        check({tag, "_stat_preempt"},  64'(stat_preempt),  64'((n_swap > 65535) ? 65535 : n_swap));
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Dispatch one task and follow it to completion. Entered and left at a
    // negedge; the next head may be presented immediately (back-to-back).
    task automatic run_task(input logic [TID_W-1:0] tid, input logic [INFO_W-1:0] info,
                            input int ev_kind, input int ev_cyc, input int ready_dly,
                            input bit hold);
        int k;
        int x;
        int outcome;
        bit ev_hit;
        logic [INFO_W-1:0] rem;

        head_valid = 1'b1;
        head_tid   = tid;
        head_info  = info;
        tick();
        n_disp++;
        if (!hold) head_valid = 1'b0;

        if (info == '0) begin
            head_valid = 1'b0;
            check("zero_pulses", 64'(pulses()), 64'(5'b10100));
            check("zero_out_tid", 64'(out_tid), 64'(tid));
            return;
        end
        check("disp_pulses", 64'(pulses()), 64'(5'b11000));
        check("disp_run_tid", 64'(run_tid), 64'(tid));

        // Expected fate from plain arithmetic.
        k      = (info < 32'(SLICE_LEN)) ? int'(info) : SLICE_LEN;
        ev_hit = (ev_kind != EV_NONE) && (ev_cyc >= 1) && (ev_cyc <= k);
        x      = ev_hit ? ev_cyc : k;
        rem    = '0;
        if (ev_hit) begin
            if (ev_kind == EV_DONE || ev_kind == EV_DB || ev_kind == EV_ALL) outcome = OUT_RET;
            else if (ev_kind == EV_BLK || ev_kind == EV_BP)                   outcome = OUT_BLK;
            else begin
                outcome = OUT_SWAP;
                rem     = info - 32'(ev_cyc - 1);
            end
        end else if (info <= 32'(SLICE_LEN)) begin
            outcome = OUT_RET;
        end else begin
            outcome = OUT_SWAP;
            rem     = info - 32'(SLICE_LEN);
        end

        for (int j = 1; j <= x; j++) begin
            if (ev_hit && j == x) begin
                done_req    = (ev_kind == EV_DONE) || (ev_kind == EV_DB) || (ev_kind == EV_ALL);
                block_req   = (ev_kind == EV_BLK) || (ev_kind == EV_DB) || (ev_kind == EV_ALL) || (ev_kind == EV_BP);
                preempt_req = (ev_kind == EV_PRE) || (ev_kind == EV_ALL) || (ev_kind == EV_BP);
            end
            tick();
            done_req    = 1'b0;
            block_req   = 1'b0;
            preempt_req = 1'b0;
            if (j < x) begin
                check("run_pulses", 64'(pulses()), 64'(5'b01000));
                check("run_tid", 64'(run_tid), 64'(tid));
            end
        end

        case (outcome)
            OUT_RET: begin
                check("retire_pulses", 64'(pulses()), 64'(5'b00100));
                check("retire_out_tid", 64'(out_tid), 64'(tid));
            end
            OUT_BLK: begin
                check("blk_pulses", 64'(pulses()), 64'(5'b00010));
                check("blk_out_tid", 64'(out_tid), 64'(tid));
            end
            default: begin
                check("enq_pulses", 64'(pulses()), 64'(5'b00001));
                check("enq_tid", 64'(enq_tid), 64'(tid));
                check("enq_info", 64'(enq_info), 64'(rem));
            end
        endcase

        if (outcome != OUT_SWAP) begin
            head_valid = 1'b0;
            return;
        end

        n_swap++;
        pool.push_back('{tid: tid, info: rem});
        for (int r = 1; r <= ready_dly; r++) begin
            enq_ready = (r == ready_dly);
            tick();
            enq_ready = 1'b0;
            if (r < ready_dly) begin
                check("swap_pulses", 64'(pulses()), 64'(5'b00001));
                check("swap_enq_tid", 64'(enq_tid), 64'(tid));
                check("swap_enq_info", 64'(enq_info), 64'(rem));
            end else begin
                check("swap_exit_pulses", 64'(pulses()), 64'(5'b00000));
            end
        end
        head_valid = 1'b0;
    endtask

    initial begin
        task_t t;
        int    src;

        rst         = 1'b1;
        head_valid  = 1'b0;
        head_tid    = '0;
        head_info   = '0;
        enq_ready   = 1'b0;
        done_req    = 1'b0;
        block_req   = 1'b0;
        preempt_req = 1'b0;

        @(negedge clk);
        check("reset_outputs", all_outputs(), 64'd0);
        check_stats("reset");
        rst = 1'b0;
        tick();
        check("idle_pulses", 64'(pulses()), 64'(5'b00000));

        // Short task retires by work exhaustion.
        run_task(4'd5, 32'd3, EV_NONE, 0, 1, 1'b0);
        // Slice expiry with enq_ready delayed: enq_info = 10 - 4.
        run_task(4'd2, 32'd10, EV_NONE, 0, 3, 1'b0);
        // done and block together: done wins.
        run_task(4'd7, 32'd5, EV_DB, 2, 1, 1'b0);
        // Preempt on second RUN cycle, then back-to-back zero-work task.
        run_task(4'd4, 32'd8, EV_PRE, 2, 1, 1'b1);
        run_task(4'd9, 32'd0, EV_NONE, 0, 1, 1'b0);
        check_stats("directed");
        // Boundaries: info == SLICE_LEN retires, info == SLICE_LEN+1 leaves 1,
        // info == 1, maximum info, and every priority combination.
        run_task(4'd1, 32'(SLICE_LEN), EV_NONE, 0, 1, 1'b1);
        run_task(4'd3, 32'(SLICE_LEN + 1), EV_NONE, 0, 2, 1'b0);
        run_task(4'd6, 32'd1, EV_NONE, 0, 1, 1'b0);
        run_task(4'd15, 32'hFFFF_FFFF, EV_NONE, 0, 2, 1'b1);
        run_task(4'd8, 32'd6, EV_ALL, 1, 1, 1'b0);
        run_task(4'd10, 32'd6, EV_BP, 3, 1, 1'b0);
        run_task(4'd11, 32'd6, EV_BLK, 4, 1, 1'b0);
        run_task(4'd12, 32'd2, EV_PRE, 2, 1, 1'b0);
        check_stats("boundary");

        // Reset in the middle of RUN: outputs clear at once, no enq afterwards.
        head_valid = 1'b1;
        head_tid   = 4'd3;
        head_info  = 32'd20;
        tick();
        head_valid = 1'b0;
        tick();
        check("pre_reset_run", 64'(run_valid), 64'd1);
        #2 rst = 1'b1;
        #1 check("midrun_reset_outputs", all_outputs(), 64'd0);
        n_disp = 0;
        n_swap = 0;
        check_stats("midrun_reset");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_reset_quiet", all_outputs(), 64'd0);
        end

        // Randomized tasks, mixing fresh ones with previously re-enqueued ones.
        for (int n = 0; n < 150; n++) begin
            src = int'($urandom_range(0, 1));
            if (src == 1 && pool.size() != 0) begin
                t = pool.pop_front();
            end else begin
                t.tid  = TID_W'($urandom);
                t.info = 32'($urandom_range(0, 12));
            end
            run_task(t.tid, t.info, int'($urandom_range(0, 9)) % 7, int'($urandom_range(1, 6)),
                     int'($urandom_range(1, 4)), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
                    tick();
                    check("gap_idle", 64'(pulses()), 64'(5'b00000));
                end
            end
        end
        check_stats("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sr_task_dispatcher
